// File: rtl/rst_seq_ctrl_if.sv
// Handshake bundle between the reset sequencer and the domains it releases.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_STAGES = 3
);
  logic                  sw_rst_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  seq_done;
  logic                  seq_err;
  logic [2:0]            err_stage;
  logic [2:0]            cur_state;

  // Environment side: requests re-sequence and reports per-domain init-done.
  modport master (
    output sw_rst_req, stage_ack,
    input  stage_rst, seq_done, seq_err, err_stage, cur_state
  );

  // Sequencer side.
  modport slave (
    input  sw_rst_req, stage_ack,
    output stage_rst, seq_done, seq_err, err_stage, cur_state
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: stretches the generator reset, then releases each domain
// reset in ascending order, waiting for that domain's init-done acknowledge
// (with timeout) and a fixed gap before releasing the next one.
module rst_seq_ctrl #(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned STRETCH_CYCLES = 5,
  parameter int unsigned STAGE_GAP      = 4,
  parameter int unsigned TIMEOUT        = 256,
  parameter int unsigned CNT_W          = 16
) (
  input  logic         clk_fr,
  input  logic         rst,
  rst_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    WAIT_ACK = 3'd1,
    GAP      = 3'd2,
    DONE     = 3'd3,
    ERR      = 3'd4
  } state_t;

  localparam logic [2:0]       LAST_IDX    = 3'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] STRETCH_END = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_END     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            idx;
  logic [NUM_STAGES-1:0] stage_rst_q;
  logic                  seq_done_q;
  logic                  seq_err_q;
  logic [2:0]            err_stage_q;

  logic                  ack_cur;
  logic [NUM_STAGES-1:0] next_mask;

  // Pick the acknowledge of the current stage and the one-hot of the next stage;
  // a loop keeps widths exact for any NUM_STAGES in 1..8.
  always_comb begin
    ack_cur   = 1'b0;
    next_mask = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (3'(i) == idx)         ack_cur      = bus.stage_ack[i];
      if (3'(i) == idx + 3'd1)  next_mask[i] = 1'b1;
    end
  end

  // Sequencing FSM; rst and a software request both restart the whole sequence.
  always_ff @(posedge clk_fr) begin
    if (rst || bus.sw_rst_req) begin
      state       <= HOLD;
      cnt         <= '0;
      idx         <= '0;
      stage_rst_q <= '1;
      seq_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      err_stage_q <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == STRETCH_END) begin
            stage_rst_q[0] <= 1'b0;
            cnt            <= '0;
            state          <= WAIT_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_cur) begin
            if (idx == LAST_IDX) begin
              seq_done_q <= 1'b1;
              state      <= DONE;
            end else begin
              cnt   <= '0;
              state <= GAP;
            end
          end else if (cnt == TIMEOUT_END) begin
            seq_err_q   <= 1'b1;
            err_stage_q <= idx;
            stage_rst_q <= '1;
            state       <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            idx         <= idx + 3'd1;
            stage_rst_q <= stage_rst_q & ~next_mask;
            cnt         <= '0;
            state       <= WAIT_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= DONE;
        ERR:     state <= ERR;
        default: state <= HOLD;
      endcase
    end
  end

  assign bus.stage_rst = stage_rst_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.err_stage = err_stage_q;
  assign bus.cur_state = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed vector table, hand-written corner cases,
// then randomized traffic against a deadline-based reference model.
module tb_rst_seq_ctrl;

  localparam int unsigned N       = 3;
  localparam int unsigned STRETCH = 5;
  localparam int unsigned SGAP    = 4;
  localparam int unsigned TMO     = 256;

  logic clk = 1'b0;
  logic rst;

  rst_seq_ctrl_if #(.NUM_STAGES(N)) bus ();

  rst_seq_ctrl #(
    .NUM_STAGES(N), .STRETCH_CYCLES(STRETCH), .STAGE_GAP(SGAP),
    .TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .clk_fr(clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    bit          r;
    bit          s;
    logic [2:0]  ack;
    int unsigned n;     // edges to apply these inputs
    logic [2:0]  sr;    // expected after the last edge
    bit          dn;
    bit          er;
    logic [2:0]  es;
    logic [2:0]  st;
    string       tag;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] sr, input bit dn, input bit er,
                         input logic [2:0] es, input logic [2:0] st);
    chk({tag, ".stage_rst"}, 32'(bus.stage_rst), 32'(sr));
    chk({tag, ".seq_done"},  32'(bus.seq_done),  32'(dn));
    chk({tag, ".seq_err"},   32'(bus.seq_err),   32'(er));
    chk({tag, ".err_stage"}, 32'(bus.err_stage), 32'(es));
    chk({tag, ".cur_state"}, 32'(bus.cur_state), 32'(st));
  endtask

  // Apply inputs for n edges; sampling happens 1 time unit after each edge.
  task automatic run(input bit r, input bit s, input logic [2:0] a, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      rst = r; bus.sw_rst_req = s; bus.stage_ack = a;
      @(posedge clk); #1;
    end
  endtask

  task automatic add(input bit r, input bit s, input logic [2:0] a, input int unsigned n,
                     input logic [2:0] sr, input bit dn, input bit er, input logic [2:0] es,
                     input logic [2:0] st, input string tag);
    vec_t v;
    v.r = r; v.s = s; v.ack = a; v.n = n; v.sr = sr; v.dn = dn; v.er = er;
    v.es = es; v.st = st; v.tag = tag;
    tbl.push_back(v);
  endtask

  // Reference model: absolute-cycle deadlines instead of a running counter.
  int unsigned m_rel;      // stages released so far
  bit          m_wait, m_done, m_err;
  int unsigned m_es;
  longint      cyc, m_rel_at, m_to_at;

  task automatic model_edge(input bit r, input bit s, input logic [2:0] a);
    if (r || s) begin
      m_rel = 0; m_wait = 0; m_done = 0; m_err = 0; m_es = 0;
      m_rel_at = cyc + STRETCH;
    end else if (!m_err && !m_done) begin
      if (m_wait) begin
        if (a[m_rel-1]) begin
          m_wait = 0;
          if (m_rel == N) m_done = 1;
          else            m_rel_at = cyc + SGAP;
        end else if (cyc == m_to_at) begin
          m_err = 1; m_es = m_rel - 1; m_rel = 0; m_wait = 0;
        end
      end else if (cyc == m_rel_at) begin
        m_rel++; m_wait = 1; m_to_at = cyc + TMO;
      end
    end
  endtask

  initial begin
    logic [2:0] exp_sr;
    logic [2:0] exp_st;
    logic [2:0] a;
    bit         r, s;
    int unsigned mode;

    rst = 1'b1; bus.sw_rst_req = 1'b0; bus.stage_ack = '0;

    // Normal sequence, acks tied high
    add(1,0,3'b111,1,   3'b111,0,0,0,0, "s1.reset");
    add(0,0,3'b111,4,   3'b111,0,0,0,0, "s1.stretch");
    add(0,0,3'b111,1,   3'b110,0,0,0,1, "s1.rel0");
    add(0,0,3'b111,1,   3'b110,0,0,0,2, "s1.ack0");
    add(0,0,3'b111,3,   3'b110,0,0,0,2, "s1.gap0");
    add(0,0,3'b111,1,   3'b100,0,0,0,1, "s1.rel1");
    add(0,0,3'b111,1,   3'b100,0,0,0,2, "s1.ack1");
    add(0,0,3'b111,4,   3'b000,0,0,0,1, "s1.rel2");
    add(0,0,3'b111,1,   3'b000,1,0,0,3, "s1.done");
    add(0,0,3'b000,5,   3'b000,1,0,0,3, "s1.hold_done");
    // Timeout on stage 1
    add(1,0,3'b000,1,   3'b111,0,0,0,0, "s2.reset");
    add(0,0,3'b101,5,   3'b110,0,0,0,1, "s2.rel0");
    add(0,0,3'b101,1,   3'b110,0,0,0,2, "s2.ack0");
    add(0,0,3'b101,4,   3'b100,0,0,0,1, "s2.rel1");
    add(0,0,3'b101,255, 3'b100,0,0,0,1, "s2.wait255");
    add(0,0,3'b101,1,   3'b111,0,1,1,4, "s2.timeout");
    add(0,0,3'b111,10,  3'b111,0,1,1,4, "s2.hold_err");
    add(0,1,3'b111,1,   3'b111,0,0,0,0, "s2.sw_clear");
    // Spurious acks of other stages while stage 0 waits
    add(1,0,3'b000,1,   3'b111,0,0,0,0, "s6.reset");
    add(0,0,3'b000,5,   3'b110,0,0,0,1, "s6.rel0");
    add(0,0,3'b100,1,   3'b110,0,0,0,1, "s6.spur2");
    add(0,0,3'b010,3,   3'b110,0,0,0,1, "s6.spur1");
    add(0,0,3'b001,1,   3'b110,0,0,0,2, "s6.ack0");

    foreach (tbl[i]) begin
      run(tbl[i].r, tbl[i].s, tbl[i].ack, tbl[i].n);
      chk_all(tbl[i].tag, tbl[i].sr, tbl[i].dn, tbl[i].er, tbl[i].es, tbl[i].st);
    end

    // Ack arrives on the final timeout edge of stage 1
    run(1,0,3'b000,1);
    run(0,0,3'b001,5);  chk_all("s3.rel0", 3'b110,0,0,0,1);
    run(0,0,3'b001,1);
    run(0,0,3'b001,4);  chk_all("s3.rel1", 3'b100,0,0,0,1);
    run(0,0,3'b001,255); chk_all("s3.wait255", 3'b100,0,0,0,1);
    run(0,0,3'b011,1);  chk_all("s3.last_edge_ack", 3'b100,0,0,0,2);
    run(0,0,3'b011,4);  chk_all("s3.rel2", 3'b000,0,0,0,1);

    // Software re-sequence while in GAP, then identical timing
    run(1,0,3'b111,1);
    run(0,0,3'b111,6);  chk_all("s4.gap", 3'b110,0,0,0,2);
    run(0,0,3'b111,1);
    run(0,1,3'b111,1);  chk_all("s4.sw", 3'b111,0,0,0,0);
    run(0,0,3'b111,4);  chk_all("s4.stretch", 3'b111,0,0,0,0);
    run(0,0,3'b111,1);  chk_all("s4.rel0", 3'b110,0,0,0,1);
    run(0,0,3'b111,5);  chk_all("s4.rel1", 3'b100,0,0,0,1);
    run(0,0,3'b111,5);  chk_all("s4.rel2", 3'b000,0,0,0,1);
    run(0,0,3'b111,1);  chk_all("s4.done", 3'b000,1,0,0,3);

    // rst mid-WAIT_ACK on stage 2
    run(1,0,3'b011,1);
    run(0,0,3'b011,15); chk_all("s5.wait2", 3'b000,0,0,0,1);
    run(0,0,3'b011,3);  chk_all("s5.still_wait2", 3'b000,0,0,0,1);
    run(1,0,3'b011,1);  chk_all("s5.rst", 3'b111,0,0,0,0);
    run(0,0,3'b011,4);  chk_all("s5.stretch", 3'b111,0,0,0,0);
    run(0,0,3'b011,1);  chk_all("s5.rel0", 3'b110,0,0,0,1);

    // Randomized traffic against the reference model
    cyc = 0;
    run(1,0,3'b000,1);
    model_edge(1,0,3'b000);
    for (int unsigned seg = 0; seg < 12; seg++) begin
      mode = seg % 3;
      for (int unsigned k = 0; k < 700; k++) begin
        r = ($urandom_range(0,399) == 0);
        s = ($urandom_range(0,299) == 0);
        a = '0;
        for (int b = 0; b < 3; b++) begin
          if (mode == 0) a[b] = 1'($urandom_range(0,1));
          else if (mode == 1) a[b] = ($urandom_range(0,39) == 0);
        end
        run(r, s, a, 1);
        cyc++;
        model_edge(r, s, a);
        exp_sr = m_err ? 3'b111 : 3'(~((32'd1 << m_rel) - 1));
        exp_st = m_err ? 3'd4 : m_done ? 3'd3 : m_wait ? 3'd1 : (m_rel == 0) ? 3'd0 : 3'd2;
        chk_all("rand", exp_sr, m_done, m_err, 3'(m_es), exp_st);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
